// File: rtl/ram_fifo_ctrl.sv
// ============================================================================
// ram_fifo_ctrl: pointer/flow control turning a 64x8 dual-port RAM into a FWFT
// FIFO with a 3-entry registered output buffer. Option: RAM_FIFO_AF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_fifo_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int AF_THRESH = 56
) (
  input  logic              clk,
  input  logic              rst,
`ifdef RAM_FIFO_AF_EN
  output logic              almost_full,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   level,
  output logic [DATA_W-1:0] ram_data_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic              ram_we_a,
  output logic [DATA_W-1:0] ram_data_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_q_b
);

  localparam logic [ADDR_W:0] C_FULL = (ADDR_W+1)'(1 << ADDR_W);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_count_q, ram_count_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        buf_count_q, buf_count_d;
  logic [DATA_W-1:0] buf_q [3];
  logic [DATA_W-1:0] buf_d [3];

  logic       push;
  logic       issue;
  logic       pop;
  logic [1:0] cap_idx;

  always_comb begin
    in_ready  = !rst && (ram_count_q != C_FULL);
    push      = in_valid && in_ready;
    out_valid = (buf_count_q != 2'd0);
    pop       = out_valid && out_ready;
    // Only registered terms feed issue, keeping out_ready off the port-B path.
    issue     = !rst && (ram_count_q != '0) &&
                (({1'b0, buf_count_q} + {2'b00, inflight_q}) < 3'd3);

    wr_ptr_d    = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d    = rd_ptr_q + ADDR_W'(issue);
    ram_count_d = ram_count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
    inflight_d  = issue;
    buf_count_d = buf_count_q + 2'(inflight_q) - 2'(pop);

    // Head lives in buf[0]; a pop shifts, then returning read data lands at the tail.
    buf_d[0] = pop ? buf_q[1] : buf_q[0];
    buf_d[1] = pop ? buf_q[2] : buf_q[1];
    buf_d[2] = pop ? '0       : buf_q[2];
    cap_idx  = buf_count_q - 2'(pop);
    if (inflight_q) begin
      case (cap_idx)
        2'd0:    buf_d[0] = ram_q_b;
        2'd1:    buf_d[1] = ram_q_b;
        default: buf_d[2] = ram_q_b;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      inflight_q  <= 1'b0;
      buf_count_q <= 2'd0;
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      inflight_q  <= inflight_d;
      buf_count_q <= buf_count_d;
      for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign out_data   = buf_q[0];
  assign level      = ram_count_q + (ADDR_W+1)'(inflight_q) + (ADDR_W+1)'(buf_count_q);
  assign ram_addr_a = wr_ptr_q;
  assign ram_data_a = in_data;
  assign ram_we_a   = push;
  assign ram_addr_b = rd_ptr_q;
  assign ram_we_b   = 1'b0;
  assign ram_data_b = '0;

`ifdef RAM_FIFO_AF_EN
  logic af_q, af_d;

  always_comb begin
    af_d = (level >= (ADDR_W+1)'(AF_THRESH));
  end

  always_ff @(posedge clk) begin
    if (rst) af_q <= 1'b0;
    else     af_q <= af_d;
  end

  assign almost_full = af_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
// ============================================================================
// tb_ram_fifo_ctrl: self-checking bench for ram_fifo_ctrl with a behavioural
// RAM and a queue-based scoreboard. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [6:0] level;
  logic [7:0] ram_data_a;
  logic [5:0] ram_addr_a;
  logic       ram_we_a;
  logic [7:0] ram_data_b;
  logic [5:0] ram_addr_b;
  logic       ram_we_b;
  logic [7:0] ram_q_b;
`ifdef RAM_FIFO_AF_EN
  logic       almost_full;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] q [$];

  ram_fifo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
`ifdef RAM_FIFO_AF_EN
    .almost_full(almost_full),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .ram_data_a (ram_data_a),
    .ram_addr_a (ram_addr_a),
    .ram_we_a   (ram_we_a),
    .ram_data_b (ram_data_b),
    .ram_addr_b (ram_addr_b),
    .ram_we_b   (ram_we_b),
    .ram_q_b    (ram_q_b)
  );

  always #5 clk = ~clk;

  // 64x8 dual-port RAM with registered read on port B
  logic [7:0] ram_mem [64];
  always @(posedge clk) begin
    if (ram_we_a) ram_mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= ram_mem[ram_addr_b];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
      n_checks++; if (ram_we_a !== 1'b0) begin n_fail++; $display("FAIL reset_we_a: got %b, expected 0", ram_we_a); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
      n_checks++; if (level !== 7'd0) begin n_fail++; $display("FAIL reset_level: got %0d, expected 0", level); end
      n_checks++; if (ram_we_b !== 1'b0 || ram_data_b !== 8'h00) begin n_fail++; $display("FAIL reset_port_b: we %b data %0h, expected 0 0", ram_we_b, ram_data_b); end
    end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %0h, expected 0", out_data); end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    q.delete();
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready: got %b, expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid t+%0d: got %b, expected 0", c, out_valid); end
      n_checks++; if (level !== 7'd1) begin n_fail++; $display("FAIL lat_level t+%0d: got %0d, expected 1", c, level); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_fail++; $display("FAIL lat_out t+3: valid %b data %0h, expected 1 a5", out_valid, out_data); end
    n_checks++; if (level !== 7'd1) begin n_fail++; $display("FAIL lat_level t+3: got %0d, expected 1", level); end
    tick();
    out_ready = 1'b0;
    #1;
    n_checks++; if (level !== 7'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_after_pop: level %0d valid %b, expected 0 0", level, out_valid); end
    tick();
  endtask

  task automatic test_fill();
    int idx;
    bit saw_ready;
    out_ready = 1'b0;
    for (int i = 0; i < 67; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_accept %0d: in_ready %b, expected 1", i, in_ready); end
      tick();
    end
    in_data = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0 || ram_we_a !== 1'b0) begin n_fail++; $display("FAIL fill_full: in_ready %b we_a %b, expected 0 0", in_ready, ram_we_a); end
      n_checks++; if (level !== 7'd67) begin n_fail++; $display("FAIL fill_level: got %0d, expected 67", level); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    idx = 0; saw_ready = 1'b0;
    for (int c = 0; c < 300 && idx < 67; c++) begin
      #1;
      if (in_ready) saw_ready = 1'b1;
      if (out_valid) begin
        n_checks++; if (out_data !== 8'(idx)) begin n_fail++; $display("FAIL fill_drain %0d: got %0h, expected %0h", idx, out_data, 8'(idx)); end
        idx++;
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (idx != 67) begin n_fail++; $display("FAIL fill_drain_count: got %0d, expected 67", idx); end
    n_checks++; if (saw_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_return: got %b, expected 1", saw_ready); end
    #1;
    n_checks++; if (level !== 7'd0) begin n_fail++; $display("FAIL fill_final_level: got %0d, expected 0", level); end
    tick();
  endtask

  task automatic test_stream();
    int pushed, popped, first_pop;
    bit acc;
    pushed = 0; popped = 0; first_pop = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 400 && popped < 200; c++) begin
      in_valid = (pushed < 200);
      in_data  = 8'(pushed);
      #1;
      n_checks++; if (level !== 7'(pushed - popped)) begin n_fail++; $display("FAIL stream_level c%0d: got %0d, expected %0d", c, level, pushed - popped); end
      acc = in_valid && in_ready;
      if (in_valid) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c%0d: got %b, expected 1", c, in_ready); end
      end
      if (first_pop >= 0) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_gap c%0d: out_valid %b, expected 1", c, out_valid); end
      end
      if (out_valid) begin
        if (first_pop < 0) first_pop = c;
        n_checks++; if (out_data !== 8'(popped)) begin n_fail++; $display("FAIL stream_data %0d: got %0h, expected %0h", popped, out_data, 8'(popped)); end
        popped++;
      end
      if (acc) pushed++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (popped != 200) begin n_fail++; $display("FAIL stream_count: got %0d, expected 200", popped); end
    n_checks++; if (first_pop != 3) begin n_fail++; $display("FAIL stream_latency: got %0d, expected 3", first_pop); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h80 + i);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (level !== 7'd10) begin n_fail++; $display("FAIL mid_level_before: got %0d, expected 10", level); end
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b, expected 0", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
    #1;
    n_checks++; if (level !== 7'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_rst: level %0d valid %b, expected 0 0", level, out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b, expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_early_valid t+%0d: got %b, expected 0", c, out_valid); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin n_fail++; $display("FAIL mid_out: valid %b data %0h, expected 1 3c", out_valid, out_data); end
    tick();
    out_ready = 1'b0;
    #1;
    n_checks++; if (level !== 7'd0) begin n_fail++; $display("FAIL mid_final_level: got %0d, expected 0", level); end
    tick();
  endtask

  task automatic test_random();
    int p_in, p_out;
    q.delete();
    for (int c = 0; c < 1200; c++) begin
      if (c % 150 == 0) begin
        p_in  = $urandom_range(10, 100);
        p_out = $urandom_range(0, 100);
      end
      in_valid  = ($urandom_range(1, 100) <= p_in);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(1, 100) <= p_out);
      #1;
      n_checks++; if (level !== 7'(q.size())) begin n_fail++; $display("FAIL rand_level c%0d: got %0d, expected %0d", c, level, q.size()); end
      if (q.size() < 64) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rand_in_ready c%0d: got %b, expected 1 (held %0d)", c, in_ready, q.size()); end
      end
      if (q.size() == 67) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rand_full c%0d: got %b, expected 0", c, in_ready); end
      end
      if (q.size() == 0) begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_empty_valid c%0d: got %b, expected 0", c, out_valid); end
      end
      if (out_valid && out_ready && q.size() > 0) begin
        n_checks++; if (out_data !== q[0]) begin n_fail++; $display("FAIL rand_data c%0d: got %0h, expected %0h", c, out_data, q[0]); end
        void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(in_data);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

`ifdef RAM_FIFO_AF_EN
  task automatic test_almost_full();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 56; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      #1;
      n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL af_early %0d: got %b, expected 0", i, almost_full); end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_checks++; if (level !== 7'd56 || almost_full !== 1'b0) begin n_fail++; $display("FAIL af_at56: level %0d af %b, expected 56 0", level, almost_full); end
    tick();
    out_ready = 1'b1;
    #1;
    n_checks++; if (almost_full !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL af_rise: af %b valid %b, expected 1 1", almost_full, out_valid); end
    tick();
    out_ready = 1'b0;
    #1;
    n_checks++; if (level !== 7'd55 || almost_full !== 1'b1) begin n_fail++; $display("FAIL af_at55: level %0d af %b, expected 55 1", level, almost_full); end
    tick();
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL af_fall: got %b, expected 0", almost_full); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_stream();
    test_reset_mid();
    test_random();
`ifdef RAM_FIFO_AF_EN
    test_almost_full();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
